// File: rtl/match_monitor.sv
// rtl/match_monitor.sv - match counter, last-match position, threshold alarm and four-phase snapshot port
// Consumes the one-cycle match pulse of a sequence detector; all outputs come straight from flops.
module match_monitor #(
  parameter int CNT_W  = 8,
  parameter int POS_W  = 16,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             en,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] snap_count,
  output logic [POS_W-1:0] snap_pos,
  output logic [CNT_W-1:0] count,
  output logic [POS_W-1:0] last_pos,
  output logic             sat,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
  // A threshold the counter can never hold would otherwise alias onto a truncated value.
  localparam bit ALARM_EN = (THRESH > 0) && ($clog2(THRESH + 1) <= CNT_W);

  typedef enum logic {A_IDLE, A_ALARM} a_state_e;
  typedef enum logic {R_IDLE, R_ACK}   r_state_e;

  logic [CNT_W-1:0] count_q, count_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] last_pos_q, last_pos_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] snap_count_q;
  logic [POS_W-1:0] snap_pos_q;
  a_state_e         a_state_q;
  r_state_e         r_state_q;
  logic             match;

  assign match = w & en;

  always_comb begin
    count_d    = count_q;
    pos_d      = pos_q;
    last_pos_d = last_pos_q;
    sat_d      = sat_q;
    if (clr) begin
      count_d    = '0;
      pos_d      = '0;
      last_pos_d = '0;
      sat_d      = 1'b0;
    end else begin
      if (en) begin
        pos_d = pos_q + POS_W'(1);
      end
      if (match) begin
        last_pos_d = pos_q;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
        if (count_d == CNT_MAX) begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      pos_q      <= '0;
      last_pos_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      pos_q      <= pos_d;
      last_pos_q <= last_pos_d;
      sat_q      <= sat_d;
    end
  end

  // Alarm keys off the next count so it rises on the same edge as the count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state_q <= A_IDLE;
    end else begin
      case (a_state_q)
        A_IDLE: begin
          if (ALARM_EN && !clr && (count_d == THRESH_V)) begin
            a_state_q <= A_ALARM;
          end
        end
        A_ALARM: begin
          if (clr) begin
            a_state_q <= A_IDLE;
          end
        end
        default: a_state_q <= A_IDLE;
      endcase
    end
  end

  // Snapshot captures pre-edge live values, so a coincident match or clear only affects live state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q    <= R_IDLE;
      snap_count_q <= '0;
      snap_pos_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (rd_req) begin
            snap_count_q <= count_q;
            snap_pos_q   <= last_pos_q;
            r_state_q    <= R_ACK;
          end
        end
        R_ACK: begin
          if (!rd_req) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign count      = count_q;
  assign last_pos   = last_pos_q;
  assign sat        = sat_q;
  assign alarm      = (a_state_q == A_ALARM);
  assign rd_ack     = (r_state_q == R_ACK);
  assign snap_count = snap_count_q;
  assign snap_pos   = snap_pos_q;

endmodule

// File: tb/tb_match_monitor.sv
// tb/tb_match_monitor.sv - directed and randomized checks of match_monitor against an arithmetic model
// Small widths make saturation and position wrap reachable quickly.
module tb_match_monitor;

  localparam int CNT_W  = 3;
  localparam int POS_W  = 4;
  localparam int THRESH = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int PMOD   = 1 << POS_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             w, en, clr, rd_req;
  logic             rd_ack, sat, alarm;
  logic [CNT_W-1:0] snap_count, count;
  logic [POS_W-1:0] snap_pos, last_pos;

  always #5 clk = ~clk;

  match_monitor #(.CNT_W(CNT_W), .POS_W(POS_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .w(w), .en(en), .clr(clr), .rd_req(rd_req),
    .rd_ack(rd_ack), .snap_count(snap_count), .snap_pos(snap_pos),
    .count(count), .last_pos(last_pos), .sat(sat), .alarm(alarm)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_count, m_pos, m_last, m_sc, m_sp;
  bit m_sat, m_alarm, m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_pos = 0; m_last = 0; m_sc = 0; m_sp = 0;
    m_sat = 0; m_alarm = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit iw, input bit ien, input bit iclr, input bit ireq);
    if (!m_ack && ireq) begin
      m_sc  = m_count;
      m_sp  = m_last;
      m_ack = 1;
    end else if (m_ack && !ireq) begin
      m_ack = 0;
    end
    if (iclr) begin
      m_count = 0; m_pos = 0; m_last = 0; m_sat = 0; m_alarm = 0;
    end else begin
      if (iw && ien) begin
        m_last  = m_pos;
        m_count = (m_count < MAXC) ? m_count + 1 : MAXC;
        if (m_count == MAXC) m_sat = 1;
        if (THRESH != 0 && m_count == THRESH) m_alarm = 1;
      end
      if (ien) m_pos = (m_pos + 1) % PMOD;
    end
  endtask

  task automatic check_all();
    check("count", count, m_count);
    check("last_pos", last_pos, m_last);
    check("sat", sat, m_sat);
    check("alarm", alarm, m_alarm);
    check("rd_ack", rd_ack, m_ack);
    check("snap_count", snap_count, m_sc);
    check("snap_pos", snap_pos, m_sp);
  endtask

  task automatic cycle(input bit iw, input bit ien, input bit iclr, input bit ireq);
    w = iw; en = ien; clr = iclr; rd_req = ireq;
    @(posedge clk);
    model_edge(iw, ien, iclr, ireq);
    #1 check_all();
    @(negedge clk);
  endtask

  initial begin
    bit req;
    rst = 1'b1; w = 0; en = 0; clr = 0; rd_req = 0;
    model_reset();
    #12 check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 16; c++) cycle(c == 3 || c == 7 || c == 12, 1, 0, 0);
    check("basic_count", count, 3);
    check("basic_last", last_pos, 12);

    cycle(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
    end
    check("alarm_set", alarm, 1);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("alarm_sticky", alarm, 1);
    cycle(0, 1, 1, 0);
    check("alarm_clr", alarm, 0);
    check("count_clr", count, 0);
    cycle(1, 1, 0, 0);
    check("pos_restart", last_pos, 0);

    cycle(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
    check("sat_count", count, 7);
    check("sat_flag", sat, 1);
    cycle(1, 0, 0, 0);
    check("en0_count", count, 7);
    cycle(1, 1, 0, 0);
    check("en0_pos", last_pos, 10);

    cycle(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    check("snap_coinc", snap_count, 5);
    check("live_coinc", count, 6);
    check("ack_rise", rd_ack, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 0);
    check("ack_fall", rd_ack, 0);

    cycle(0, 1, 1, 0);
    for (int c = 0; c < 20; c++) cycle(c == 17, 1, 0, 0);
    check("pos_wrap", last_pos, 1);

    req = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) req = ~req;
      cycle($urandom_range(2) == 0, $urandom_range(7) != 0, $urandom_range(39) == 0, req);
    end

    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 1);
    check("pre_rst_ack", rd_ack, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_ack", rd_ack, 0);
    check("rst_snap_count", snap_count, 0);
    check("rst_snap_pos", snap_pos, 0);
    check("rst_count", count, 0);
    check("rst_alarm", alarm, 0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_monitor.md
# match_monitor

Downstream consumer of the Mealy 10110 sequence detector's one-cycle match output `w`. Each match is recorded in a saturating match counter, and the bit position of the most recent match is stored. An alarm is raised when a programmed match count is reached. A four-phase request/acknowledge handshake lets a host take a coherent snapshot of count and position without stopping the stream.

## Interface
- `CNT_W`, default 8: width of the match counter.
- `POS_W`, default 16: width of the bit-position counter.
- `THRESH`, default 4: match count that raises `alarm`; 0 disables the alarm.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `w`  input  1  match pulse from the detector; sampled on every rising edge.
- `en`  input  1  stream enable; the position counter advances and matches are counted only when `en`=1.
- `clr`  input  1  synchronous clear of live state.
- `rd_req`  input  1  snapshot request (four-phase).
- `rd_ack`  output  1  snapshot valid / acknowledge.
- `snap_count`  output  CNT_W  snapshot of the match counter.
- `snap_pos`  output  POS_W  snapshot of the last-match position.
- `count`  output  CNT_W  live match counter.
- `last_pos`  output  POS_W  live position of the most recent counted match.
- `sat`  output  1  the match counter has saturated.
- `alarm`  output  1  the threshold has been reached (sticky).

## Operation
- Reset clears all outputs and internal state to 0, and both FSMs go to their idle states. Reset is effective immediately, independent of `clk`.
- Position counter `pos` (internal, POS_W bits):
  - When `en`=1, `pos` increments by 1 every cycle, modulo 2^POS_W; 2^POS_W-1 wraps to 0.
  - When `en`=0, `pos` holds.
- Match event is `w`=1 AND `en`=1 at a rising edge. On a match event:
  - `last_pos` <= `pos` (the value before the increment).
  - `count` <= `count`+1, saturating at 2^CNT_W-1.
  - `sat` is set in the same edge that `count` reaches 2^CNT_W-1, and stays set until `clr` or reset.
  - A `w` pulse with `en`=0 is ignored.
- Alarm FSM, states A_IDLE and A_ALARM:
  - A_IDLE -> A_ALARM on the edge where the next value of `count` equals `THRESH`, when `THRESH`≠0.
  - A_ALARM holds until `clr`, then returns to A_IDLE.
  - `alarm` = (state==A_ALARM).
- `clr`=1 at an edge zeroes `count`, `last_pos`, `pos`, `sat` and `alarm`.
  - `clr` has priority over a simultaneous match; that match is discarded.
  - `clr` does not affect the snapshot registers or the read FSM.
- Read FSM, states R_IDLE and R_ACK:
  - R_IDLE with `rd_req`=1: capture `snap_count` <= `count` and `snap_pos` <= `last_pos`, using the pre-edge register values. Go to R_ACK.
  - A match in the capture cycle updates the live registers only; it appears in the next snapshot.
  - R_ACK: `rd_ack`=1 and the snapshot is frozen. When `rd_req`=0, go to R_IDLE and drop `rd_ack`.
  - A new request is only recognized after `rd_ack` has dropped.
  - `rd_req` held high forever keeps the FSM in R_ACK, with no recapture.

## Timing
- Match-to-`count`/`last_pos` latency: 1 cycle; the registers update at the edge that samples `w`.
- `alarm` and `sat` assert at the same edge as the `count` update that triggers them. There is no extra pipeline stage.
- `rd_req` rise -> `rd_ack` high and snapshot valid after the next rising edge (1 cycle).
- `rd_req` fall -> `rd_ack` low after the next edge (1 cycle).
- Minimum full handshake: 2 cycles.
- Simultaneous `clr` and capture: the snapshot takes the pre-clear values; live values clear.
- `rst` mid-handshake: `rd_ack` drops immediately and both snapshot registers go to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic counting:** reset, `en`=1, `w` pulses at cycles 3, 7 and 12 after reset release -> `count`=1, 2, 3 one cycle after each pulse. `last_pos`=3, 7, 12.
- **Alarm and clear:** `THRESH`=4, four pulses -> `alarm` rises on the edge where `count` becomes 4 and stays high through further pulses. `clr` -> `alarm`=0, `count`=0, `pos` restarts at 0.
- **Saturation:** `CNT_W`=3, ten pulses -> `count` stops at 7, with `sat`=1 from the 7th pulse. A `w` pulse while `en`=0 leaves `count` and `pos` unchanged.
- **Snapshot with coincident match:** `count`=5, `rd_req` rises in the same cycle as a `w` pulse -> `snap_count`=5, live `count`=6, `rd_ack`=1 next cycle. Drop `rd_req` -> `rd_ack`=0 one cycle later.
- **Position wrap:** `POS_W`=4, `en` high for 20 cycles, pulse at cycle 17 -> `last_pos`=1.
- **Reset mid-handshake:** assert `rst` while in R_ACK, with no clock edge -> `rd_ack`, `snap_count`, `snap_pos`, `count` and `alarm` all 0 immediately.
